fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Holds the program counter and fetches instruction words from instruction memory over a
//   req/valid handshake. Latches the fetched word into the instruction register on instruction_en.
//   Splits the IR into op_code/A_index/ext_op_code/B_index and sign/zero-extends the immediate.
//   Sits upstream of the controller, and also consumes the controller's pc_en/pc_src.
// PARAMETERS
//   WIDTH      16  datapath, PC and instruction word width
//   REG_BITS    4  register index width
//   IMM_BITS    8  immediate field width, IR[IMM_BITS-1:0]
// PORTS
//   clk             in   1      sole clock, rising edge
//   reset           in   1      synchronous, active-high
//   pc_en           in   1      controller: update PC at next edge
//   pc_src          in   2      00 alu_result (branch target), 01 reg_b_data (jump), 10 pc+1, 11 hold
//   instruction_en  in   1      controller: load buffered word into IR
//   alu_result      in   WIDTH  branch target computed by ALU
//   reg_b_data      in   WIDTH  register-file B read data (JAL/JCOND target)
//   mem_rd_req      out  1      instruction read request, level
//   mem_addr        out  WIDTH  read address, equals address of outstanding request
//   mem_rd_data     in   WIDTH  read data, qualified by mem_rd_valid
//   mem_rd_valid    in   1      one-cycle pulse, returns data for outstanding request
//   instr_ready     out  1      buffered word valid for current PC; controller holds FETCH until 1
//   op_code         out  4      IR[15:12]
//   A_index         out  REG_BITS  IR[11:8]
//   ext_op_code     out  4      IR[7:4]
//   B_index         out  REG_BITS  IR[3:0]
//   imm_sext        out  WIDTH  IR[7:0] sign-extended
//   imm_zext        out  WIDTH  IR[7:0] zero-extended
//   pc_out          out  WIDTH  current PC
//   pc_plus1        out  WIDTH  pc_out+1, wraps mod 2^WIDTH (JAL link value)
//   protocol_err    out  1      sticky: instruction_en while instr_ready=0
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset values: PC=0; IR=0, so all field outputs are 0; buffer=0.
//   Reset values: state=IDLE; mem_rd_req=0; instr_ready=0; protocol_err=0.
//   Reset mid-fetch: any outstanding request is abandoned. Memory must drop it on the same reset.
//   At most one outstanding read. mem_addr is held stable while mem_rd_req=1.
//   FSM (registered state; mem_rd_req=1 in REQ and STALE; instr_ready=1 only in FULL):
//     IDLE : next edge -> REQ. mem_rd_req therefore rises in the 1st cycle after reset release.
//     REQ  : mem_addr=PC. On mem_rd_valid: buffer<=mem_rd_data, then -> FULL.
//            pc_en without valid -> STALE.
//            pc_en together with valid: data discarded, stay REQ, reissue at the new PC.
//     STALE: mem_addr=address of the old request, held. Wait for mem_rd_valid, discard the data,
//            then -> REQ. pc_en in STALE updates PC and stays STALE.
//     FULL : no request. instruction_en -> IR<=buffer, 1-cycle latency (fields valid next cycle).
//            FULL stays FULL; a repeated instruction_en reloads the same word.
//            pc_en -> REQ at the new PC.
//            instruction_en with pc_en in the same cycle: IR gets the old buffer, then PC updates.
//   PC update: on the edge where pc_en=1, PC<=mux(pc_src). pc_src=11 leaves PC unchanged.
//   pc_src=11 with pc_en=1 is still treated as a PC change, so it causes a refetch.
//   pc+1 wraps FFFF->0000. No alignment or range checks.
//   instruction_en in REQ/STALE/IDLE: IR unchanged, protocol_err<=1. Only reset clears it.
//   instr_ready is registered. It never asserts in the same cycle as mem_rd_valid.
//   Field outputs and immediates are combinational from IR. pc_out/pc_plus1 are combinational from PC.
// TESTING
//   1 Reset, then memory with 0 wait states returning 16'h5A13 at addr 0:
//     mem_rd_req=1 at cycle 1, instr_ready=1 at cycle 3.
//     Then instruction_en -> op_code=5, A_index=A, ext_op_code=1, B_index=3.
//   2 IR=16'hC0F6, pc_en with pc_src=10 at PC=16'hFFFF:
//     PC=0000, refetch issued at addr 0, imm_sext=FFF6, imm_zext=00F6.
//   3 pc_en (pc_src=01, reg_b_data=0040) while a 3-wait-state read of addr 0005 is pending:
//     mem_addr stays 0005 until valid, that data is discarded, next request at 0040.
//     instr_ready rises only after the 0040 data returns.
//   4 pc_en together with mem_rd_valid in REQ:
//     data dropped, instr_ready stays 0, new request at the alu_result target.
//   5 instruction_en while in REQ: IR unchanged and protocol_err=1.
//     protocol_err remains 1 through later fetches and clears only on reset.
//   6 Reset asserted mid-STALE: the next cycle shows PC=0, mem_rd_req=0 and instr_ready=0.
//     A stray mem_rd_valid during reset is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// One outstanding read at a time: mem_rd_req is a level request, mem_addr is held
// stable while it is high, and mem_rd_valid pulses once with the read data.
interface fetch_unit_if #(
  parameter int WIDTH = 16
);

  logic             mem_rd_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rd_data;
  logic             mem_rd_valid;

  modport master (
    output mem_rd_req,
    output mem_addr,
    input  mem_rd_data,
    input  mem_rd_valid
  );

  modport slave (
    input  mem_rd_req,
    input  mem_addr,
    output mem_rd_data,
    output mem_rd_valid
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: owns the program counter, fetches one instruction word at a time
// from instruction memory, buffers it, and loads it into the instruction
// register when the controller asks. Decoded fields and immediates come
// straight from the IR. A PC change while a read is in flight leaves the read to
// complete against its original address; that data is dropped and the word for
// the new PC is requested afterwards.
module fetch_unit #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4,
  parameter int IMM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_en,
  input  logic [1:0]          pc_src,
  input  logic                instruction_en,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [WIDTH-1:0]    reg_b_data,
  fetch_unit_if.master        mem,
  output logic                instr_ready,
  output logic [3:0]          op_code,
  output logic [REG_BITS-1:0] A_index,
  output logic [3:0]          ext_op_code,
  output logic [REG_BITS-1:0] B_index,
  output logic [WIDTH-1:0]    imm_sext,
  output logic [WIDTH-1:0]    imm_zext,
  output logic [WIDTH-1:0]    pc_out,
  output logic [WIDTH-1:0]    pc_plus1,
  output logic                protocol_err
);

  localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] PC_ZERO = WIDTH'(0);

  // IDLE: one cycle after reset; REQ: read of the current PC in flight;
  // STALE: read of an old PC in flight, data to be dropped; FULL: buffer holds
  // the word for the current PC.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic             mem_rd_req_r;
  logic             instr_ready_r;
  logic             req_next_s;
  logic             ready_next_s;

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] ir_r;
  logic [WIDTH-1:0] buf_r;
  logic [WIDTH-1:0] stale_addr_r;
  logic             protocol_err_r;

  logic             buf_load_s;
  logic             ir_load_s;
  logic             stale_capture_s;
  logic             proto_set_s;

  // State register plus the registered handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      mem_rd_req_r  <= 1'b0;
      instr_ready_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      mem_rd_req_r  <= req_next_s;
      instr_ready_r <= ready_next_s;
    end
  end

  // Next-state logic for the fetch handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_REQ;
      end
      ST_REQ: begin
        if (pc_en) begin
          // Data arriving with a PC change belongs to the old PC: reissue now.
          if (mem.mem_rd_valid) begin
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_STALE;
          end
        end else if (mem.mem_rd_valid) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_STALE: begin
        if (mem.mem_rd_valid) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_STALE;
        end
      end
      ST_FULL: begin
        if (pc_en) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath control decode from the current and next state.
  always_comb begin
    req_next_s      = (state_next_s == ST_REQ) || (state_next_s == ST_STALE);
    ready_next_s    = (state_next_s == ST_FULL);
    buf_load_s      = (state_r == ST_REQ) && mem.mem_rd_valid && !pc_en;
    ir_load_s       = (state_r == ST_FULL) && instruction_en;
    stale_capture_s = (state_r == ST_REQ) && pc_en && !mem.mem_rd_valid;
    proto_set_s     = instruction_en && (state_r != ST_FULL);
    if (pc_en) begin
      case (pc_src)
        2'b00:   pc_next_s = alu_result;
        2'b01:   pc_next_s = reg_b_data;
        2'b10:   pc_next_s = pc_r + PC_ONE;
        2'b11:   pc_next_s = pc_r;
        default: pc_next_s = pc_r;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC, fetch buffer, IR, stale-request address and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r           <= PC_ZERO;
      ir_r           <= PC_ZERO;
      buf_r          <= PC_ZERO;
      stale_addr_r   <= PC_ZERO;
      protocol_err_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (buf_load_s) begin
        buf_r <= mem.mem_rd_data;
      end
      // IR takes the buffer as it was before this edge, even when the PC moves too.
      if (ir_load_s) begin
        ir_r <= buf_r;
      end
      // Remember the in-flight address so it stays on the bus while the PC moves on.
      if (stale_capture_s) begin
        stale_addr_r <= pc_r;
      end
      if (proto_set_s) begin
        protocol_err_r <= 1'b1;
      end
    end
  end

  assign mem.mem_rd_req = mem_rd_req_r;
  assign mem.mem_addr   = (state_r == ST_STALE) ? stale_addr_r : pc_r;

  assign instr_ready  = instr_ready_r;
  assign protocol_err = protocol_err_r;

  assign op_code     = ir_r[WIDTH-1 -: 4];
  assign A_index     = ir_r[WIDTH-5 -: REG_BITS];
  assign ext_op_code = ir_r[IMM_BITS-1 -: 4];
  assign B_index     = ir_r[REG_BITS-1:0];
  assign imm_sext    = {{(WIDTH-IMM_BITS){ir_r[IMM_BITS-1]}}, ir_r[IMM_BITS-1:0]};
  assign imm_zext    = {{(WIDTH-IMM_BITS){1'b0}}, ir_r[IMM_BITS-1:0]};

  assign pc_out   = pc_r;
  assign pc_plus1 = pc_r + PC_ONE;

endmodule
